core_mem_resp: RTL and testbench

- Memory responder that sits directly downstream of the core data/instruction port.
- Consumes req_val/req_addr/req_cop/req_wdata/req_size/req_be and produces ack_val/ack_rdata after a programmable latency.
- Backed by an internal word-addressed SRAM.
- Serves as the synthesizable memory model for CPU-level simulation and FPGA bring-up.

---
 rtl/core_pkg.sv | 33 +++
 rtl/core_mem_array.sv | 30 +++
 rtl/core_mem_resp.sv | 151 +++++++++++++++
 tb/tb_core_mem_resp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the core memory port: operation codes, access sizes,
// responder FSM states and the byte-lane merge used by the backing array.
package core_pkg;

  localparam logic [2:0] COP_RD = 3'd0;
  localparam logic [2:0] COP_WR = 3'd1;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/core_mem_array.sv
// Word-addressed backing store: byte-enabled synchronous write, combinational
// read. Contents start at INIT_VAL and are never touched by reset.
module core_mem_array
  import core_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] INIT_VAL = 32'h0000_0013,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH] = '{default: INIT_VAL};

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= be_merge(mem_q[waddr], wdata, be);
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/core_mem_resp.sv
// Memory responder for the core port: captures one request, waits a
// programmable (stallable) latency, then returns a single-cycle acknowledge.
module core_mem_resp
  import core_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] INIT_VAL = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_cop,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_be,
  input  logic        stall,
  output logic        ack_val,
  output logic [31:0] ack_rdata,
  output logic        busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    cop_q, cop_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          ack_val_q, ack_val_d;
  logic [31:0]   ack_rdata_q, ack_rdata_d;
  logic          busy_q, busy_d;
  logic          we_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  // Size is informational and the low/high address bits do not index the array.
  assign unused_s = ^{req_size, req_addr[31:AW+2], req_addr[1:0]};

  // Next-state, capture and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cop_d   = cop_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          addr_d  = req_addr[AW+1:2];
          cop_d   = req_cop;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 32'sd1) ? ST_ACK : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!stall) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The write commits on the edge entering ACK; the _d fields already carry the
  // live request when LATENCY = 1 jumps straight from IDLE.
  always_comb begin
    if ((state_d == ST_ACK) && (state_q != ST_ACK) && (cop_d == COP_WR)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Registered outputs: the acknowledge lands one edge after the ACK state
  always_comb begin
    ack_val_d   = 1'b0;
    ack_rdata_d = 32'h0000_0000;
    if (state_q == ST_ACK) begin
      ack_val_d = 1'b1;
      if (cop_q == COP_RD) begin
        ack_rdata_d = rdata_s;
      end else begin
        ack_rdata_d = 32'h0000_0000;
      end
    end else begin
      ack_val_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE) || (state_q == ST_ACK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      cop_q       <= 3'd0;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'd0;
      ack_val_q   <= 1'b0;
      ack_rdata_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      cop_q       <= cop_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ack_val_q   <= ack_val_d;
      ack_rdata_q <= ack_rdata_d;
      busy_q      <= busy_d;
    end
  end

  core_mem_array #(
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .waddr (addr_d),
    .wdata (wdata_d),
    .be    (be_d),
    .raddr (addr_q),
    .rdata (rdata_s)
  );

  assign ack_val   = ack_val_q;
  assign ack_rdata = ack_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_core_mem_resp.sv
// Directed bench for core_mem_resp: three instances (LATENCY 2, 3, 1) share
// clock, reset and request fields; each has its own req_val and outputs.
module tb_core_mem_resp;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  rv;
  logic [31:0] req_addr;
  logic [2:0]  req_cop;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_be;
  logic        stall;
  logic [2:0]  av;
  logic [2:0]  bz;
  logic [31:0] rd_s [3];

  int n_cmp = 0;
  int n_bad = 0;

  core_mem_resp #(.DEPTH(1024), .LATENCY(2), .INIT_VAL(32'h0000_0013)) u_dut_l2 (
    .clk(clk), .rst(rst), .req_val(rv[0]), .req_addr(req_addr), .req_cop(req_cop),
    .req_wdata(req_wdata), .req_size(req_size), .req_be(req_be), .stall(stall),
    .ack_val(av[0]), .ack_rdata(rd_s[0]), .busy(bz[0]));

  core_mem_resp #(.DEPTH(1024), .LATENCY(3), .INIT_VAL(32'h0000_0013)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_val(rv[1]), .req_addr(req_addr), .req_cop(req_cop),
    .req_wdata(req_wdata), .req_size(req_size), .req_be(req_be), .stall(stall),
    .ack_val(av[1]), .ack_rdata(rd_s[1]), .busy(bz[1]));

  core_mem_resp #(.DEPTH(1024), .LATENCY(1), .INIT_VAL(32'h0000_0013)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_val(rv[2]), .req_addr(req_addr), .req_cop(req_cop),
    .req_wdata(req_wdata), .req_size(req_size), .req_be(req_be), .stall(stall),
    .ack_val(av[2]), .ack_rdata(rd_s[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance u (called at a negedge). lat = edges from
  // capture to the start of the ack cycle; bcnt = cycles with busy high.
  task automatic txn(input int u, input logic [2:0] cop, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int st_at, input int st_len,
                     output int lat, output int bcnt, output logic [31:0] rdata);
    req_cop   = cop;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_size  = SZ_W;
    rv[u]     = 1'b1;
    lat       = -1;
    bcnt      = 0;
    rdata     = 32'h0000_0000;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == st_at) stall = 1'b1;
      if (i == st_at + st_len) stall = 1'b0;
      if (bz[u]) bcnt++;
      if (av[u]) begin
        lat   = i - 1;
        rdata = rd_s[u];
        break;
      end
    end
    rv[u] = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("single_pulse", {31'd0, av[u]}, 32'd0);
    chk("busy_drop", {31'd0, bz[u]}, 32'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int acks;
    int last;
    int seen;
    logic [31:0] r;

    rst = 1'b0; rv = 3'b000; req_addr = 32'h0; req_cop = 3'd0; req_wdata = 32'h0;
    req_size = 3'd0; req_be = 4'h0; stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack_val", {31'd0, av[0]}, 32'd0);
    chk("rst_ack_rdata", rd_s[0], 32'd0);
    chk("rst_busy", {31'd0, bz[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // LATENCY=2 read of untouched word
    txn(0, COP_RD, 32'h0000_0010, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("l2_rd_lat", 32'(lat), 32'd2);
    chk("l2_rd_data", r, 32'h0000_0013);
    chk("l2_rd_busy", 32'(bcnt), 32'd3);

    // Partial write then read back
    txn(0, COP_WR, 32'h0000_0040, 32'hA1B2_C3D4, 4'b0101, 0, 0, lat, bcnt, r);
    chk("l2_wr_lat", 32'(lat), 32'd2);
    chk("l2_wr_rdata", r, 32'h0);
    txn(0, COP_RD, 32'h0000_0040, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("l2_merge", r, 32'h00B2_00D4);

    // Address wrap, illegal cop, empty byte enables
    txn(0, COP_WR, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, lat, bcnt, r);
    txn(0, COP_RD, 32'h0000_0004, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("wrap_rd", r, 32'hDEAD_BEEF);
    txn(0, 3'd5, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 0, lat, bcnt, r);
    chk("ill_lat", 32'(lat), 32'd2);
    chk("ill_rdata", r, 32'h0);
    txn(0, COP_RD, 32'h0000_0004, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("ill_nochange", r, 32'hDEAD_BEEF);
    txn(0, COP_WR, 32'h0000_0004, 32'h0000_0000, 4'h0, 0, 0, lat, bcnt, r);
    txn(0, COP_RD, 32'h0000_0004, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("be0_nochange", r, 32'hDEAD_BEEF);

    // LATENCY=3 plain and with 4 stall cycles inside WAIT
    txn(1, COP_RD, 32'h0000_0010, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("l3_lat", 32'(lat), 32'd3);
    txn(1, COP_RD, 32'h0000_0010, 32'h0, 4'h0, 1, 4, lat, bcnt, r);
    chk("l3_stall_lat", 32'(lat), 32'd7);
    chk("l3_stall_data", r, 32'h0000_0013);
    chk("l3_stall_busy", 32'(bcnt), 32'd8);

    // Reset while a write sits in WAIT
    req_cop = COP_WR; req_addr = 32'h0000_0080; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    rv[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rv[1] = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bz[1]}, 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (av[1]) seen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (av[1]) seen++;
    end
    chk("midrst_noack", 32'(seen), 32'd0);
    txn(1, COP_RD, 32'h0000_0080, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("midrst_lost_wr", r, 32'h0000_0013);

    // LATENCY=1 single and back-to-back with req_val held
    txn(2, COP_RD, 32'h0000_0010, 32'h0, 4'h0, 0, 0, lat, bcnt, r);
    chk("l1_lat", 32'(lat), 32'd1);
    req_cop = COP_RD; req_addr = 32'h0000_0010;
    rv[2] = 1'b1;
    acks = 0;
    last = -1;
    for (int i = 0; i < 60 && acks < 10; i++) begin
      @(negedge clk);
      if (av[2]) begin
        if (last >= 0) chk("l1_gap", 32'(i - last), 32'd2);
        chk("l1_data", rd_s[2], 32'h0000_0013);
        last = i;
        acks++;
      end
    end
    rv[2] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (av[2]) acks++;
    end
    chk("l1_acks", 32'(acks), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
